// File: rtl/control_sequencer_if.sv
// Control bundle between control_sequencer and the datapath: the IR/CON_FF read-back
// plus every strobe the sequencer drives.
interface control_sequencer_if #(parameter int OPW = 5);
  logic [31:0]    IR;
  logic           CON_FF;
  logic           Run;
  logic [OPW-1:0] ALU_op;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout;
  logic Gra, Grb, Grc, R_in, R_out;
  logic PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable;
  logic ZLowIn, ZHighIn, HI_enable, LO_enable, CON_enable, OutPort_enable, RAM_write;

  modport master (
    input  IR, CON_FF,
    output Run, ALU_op,
    output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout,
    output Gra, Grb, Grc, R_in, R_out,
    output PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable,
    output ZLowIn, ZHighIn, HI_enable, LO_enable, CON_enable, OutPort_enable, RAM_write
  );

  modport slave (
    output IR, CON_FF,
    input  Run, ALU_op,
    input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout,
    input  Gra, Grb, Grc, R_in, R_out,
    input  PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable,
    input  ZLowIn, ZHighIn, HI_enable, LO_enable, CON_enable, OutPort_enable, RAM_write
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit: one control step per clock, strobes
// decoded combinationally from the present step and the opcode in IR.
module control_sequencer #(
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master ctrl
);
  localparam logic [OPW-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                             OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b01001,
                             OP_OR   = 5'b01010, OP_ADDI = 5'b01011, OP_MUL  = 5'b01110,
                             OP_DIV  = 5'b01111, OP_BR   = 5'b10010, OP_JR   = 5'b10011,
                             OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111,
                             OP_MFLO = 5'b11000, OP_HALT = 5'b11010;

  typedef enum logic [3:0] {Reset_state, T0, T1, T2, T3, T4, T5, T6, T7, Halt} state_t;

  state_t         state, next_state, last_state;
  logic [OPW-1:0] opcode;
  logic           is_alu, is_addr;
  logic           ir_unused;

  assign opcode    = ctrl.IR[31 -: OPW];
  assign ir_unused = ^ctrl.IR[31-OPW:0];

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= Reset_state;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ctrl.Run = (state != Reset_state) && (state != Halt);
    ctrl.ALU_op = '0;
    {ctrl.PCout, ctrl.ZLowout, ctrl.ZHighout, ctrl.MDRout, ctrl.HIout, ctrl.LOout,
     ctrl.InPortout, ctrl.Cout, ctrl.BAout} = '0;
    {ctrl.Gra, ctrl.Grb, ctrl.Grc, ctrl.R_in, ctrl.R_out} = '0;
    {ctrl.PC_enable, ctrl.IncPC, ctrl.MAR_enable, ctrl.MDR_enable, ctrl.MDR_read,
     ctrl.IR_enable, ctrl.Y_enable} = '0;
    {ctrl.ZLowIn, ctrl.ZHighIn, ctrl.HI_enable, ctrl.LO_enable, ctrl.CON_enable,
     ctrl.OutPort_enable, ctrl.RAM_write} = '0;

    // Final execute step of each instruction; anything unlisted behaves as nop.
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: last_state = T5;
      OP_MUL, OP_DIV, OP_BR:                          last_state = T6;
      OP_LD, OP_ST:                                   last_state = T7;
      default:                                        last_state = T3;
    endcase

    is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
              (opcode == OP_OR)  || (opcode == OP_ADDI) || (opcode == OP_MUL) ||
              (opcode == OP_DIV);
    is_addr = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST) ||
              (opcode == OP_BR);

    case (state)
      Reset_state: next_state = T0;
      T0:          next_state = T1;
      T1:          next_state = T2;
      T2:          next_state = T3;
      T3:          next_state = (opcode == OP_HALT) ? Halt : (last_state == T3) ? T0 : T4;
      // >= rather than == so an opcode swapped mid-instruction can never overrun T7.
      T4, T5, T6, T7: next_state = (state >= last_state) ? T0 : state_t'(state + 4'd1);
      default:     next_state = state;
    endcase

    if (is_alu && state >= T3 && state <= T7)      ctrl.ALU_op = opcode;
    else if (is_addr && (state == T4 || state == T5)) ctrl.ALU_op = ADD_OP;

    case (state)
      T0: begin ctrl.PCout = 1'b1; ctrl.MAR_enable = 1'b1; ctrl.IncPC = 1'b1; ctrl.ZLowIn = 1'b1; end
      T1: begin ctrl.ZLowout = 1'b1; ctrl.PC_enable = 1'b1; ctrl.MDR_read = 1'b1; ctrl.MDR_enable = 1'b1; end
      T2: begin ctrl.MDRout = 1'b1; ctrl.IR_enable = 1'b1; end
      T3: case (opcode)
        OP_MFHI: begin ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; ctrl.HIout = 1'b1; end
        OP_MFLO: begin ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; ctrl.LOout = 1'b1; end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                 begin ctrl.Grb = 1'b1; ctrl.R_out = 1'b1; ctrl.Y_enable = 1'b1; end
        OP_MUL, OP_DIV: begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.Y_enable = 1'b1; end
        OP_LDI, OP_LD, OP_ST: begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Y_enable = 1'b1; end
        OP_BR:   begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.CON_enable = 1'b1; end
        OP_JR:   begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.PC_enable = 1'b1; end
        OP_IN:   begin ctrl.InPortout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
        OP_OUT:  begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.OutPort_enable = 1'b1; end
        default: ;
      endcase
      T4: case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin ctrl.Grc = 1'b1; ctrl.R_out = 1'b1; ctrl.ZLowIn = 1'b1; end
        OP_ADDI, OP_LDI, OP_LD, OP_ST: begin ctrl.Cout = 1'b1; ctrl.ZLowIn = 1'b1; end
        OP_MUL, OP_DIV: begin
          ctrl.Grb = 1'b1; ctrl.R_out = 1'b1; ctrl.ZLowIn = 1'b1; ctrl.ZHighIn = 1'b1;
        end
        OP_BR:   begin ctrl.PCout = 1'b1; ctrl.Y_enable = 1'b1; end
        default: ;
      endcase
      T5: case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI:
                 begin ctrl.ZLowout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
        OP_MUL, OP_DIV: begin ctrl.ZLowout = 1'b1; ctrl.LO_enable = 1'b1; end
        OP_LD, OP_ST:   begin ctrl.ZLowout = 1'b1; ctrl.MAR_enable = 1'b1; end
        OP_BR:   begin ctrl.Cout = 1'b1; ctrl.ZLowIn = 1'b1; end
        default: ;
      endcase
      T6: case (opcode)
        OP_MUL, OP_DIV: begin ctrl.ZHighout = 1'b1; ctrl.HI_enable = 1'b1; end
        OP_LD:   begin ctrl.MDR_read = 1'b1; ctrl.MDR_enable = 1'b1; end
        OP_ST:   begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.MDR_enable = 1'b1; end
        OP_BR:   begin ctrl.ZLowout = 1'b1; ctrl.PC_enable = ctrl.CON_FF; end
        default: ;
      endcase
      T7: case (opcode)
        OP_LD:   begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
        OP_ST:   ctrl.RAM_write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: a per-opcode microprogram model feeds a
// queue of expected control words that is compared against the DUT every cycle.
module tb_control_sequencer;
  localparam logic [4:0] ADD_OP = 5'b00011;
  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011,
                         SUB = 5'b00100, AND_ = 5'b01001, OR_ = 5'b01010, ADDI = 5'b01011,
                         MUL = 5'b01110, DIV = 5'b01111, BR = 5'b10010, JR = 5'b10011,
                         IN_ = 5'b10101, OUT = 5'b10110, MFHI = 5'b10111, MFLO = 5'b11000,
                         NOP = 5'b11001, HALT = 5'b11010;

  localparam logic [27:0] PCO  = 28'd1 << 0,  ZLO  = 28'd1 << 1,  ZHO  = 28'd1 << 2,
                          MDRO = 28'd1 << 3,  HIO  = 28'd1 << 4,  LOO  = 28'd1 << 5,
                          INO  = 28'd1 << 6,  COUT = 28'd1 << 7,  BAO  = 28'd1 << 8,
                          GRA  = 28'd1 << 9,  GRB  = 28'd1 << 10, GRC  = 28'd1 << 11,
                          RIN  = 28'd1 << 12, ROUT = 28'd1 << 13, PCE  = 28'd1 << 14,
                          INCPC = 28'd1 << 15, MARE = 28'd1 << 16, MDRE = 28'd1 << 17,
                          MDRR = 28'd1 << 18, IRE  = 28'd1 << 19, YE   = 28'd1 << 20,
                          ZLI  = 28'd1 << 21, ZHI  = 28'd1 << 22, HIE  = 28'd1 << 23,
                          LOE  = 28'd1 << 24, CONE = 28'd1 << 25, OUTE = 28'd1 << 26,
                          RAMW = 28'd1 << 27;
  localparam logic [27:0] BUS_MASK = PCO | ZLO | ZHO | MDRO | HIO | LOO | INO | COUT | BAO | ROUT;

  typedef struct packed {
    logic [27:0] ctl;
    logic [4:0]  alu;
    logic        run;
  } exp_t;

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  control_sequencer_if ifc ();
  control_sequencer #(.OPW(5), .ADD_OP(ADD_OP)) dut (.Clock(Clock), .Clear(Clear), .ctrl(ifc.master));

  always #5 Clock = ~Clock;

  wire [27:0] obs = {ifc.RAM_write, ifc.OutPort_enable, ifc.CON_enable, ifc.LO_enable,
                     ifc.HI_enable, ifc.ZHighIn, ifc.ZLowIn, ifc.Y_enable, ifc.IR_enable,
                     ifc.MDR_read, ifc.MDR_enable, ifc.MAR_enable, ifc.IncPC, ifc.PC_enable,
                     ifc.R_out, ifc.R_in, ifc.Grc, ifc.Grb, ifc.Gra, ifc.BAout, ifc.Cout,
                     ifc.InPortout, ifc.LOout, ifc.HIout, ifc.MDRout, ifc.ZHighout,
                     ifc.ZLowout, ifc.PCout};
  wire [33:0] got = {obs, ifc.ALU_op, ifc.Run};

  function automatic exp_t mk(input logic [27:0] c, input logic [4:0] a);
    return {c, a, 1'b1};
  endfunction

  // Microprogram for one instruction: three fetch steps then the listed execute steps.
  task automatic push_instr(input logic [4:0] op, input logic con);
    q.push_back(mk(PCO | MARE | INCPC | ZLI, 5'd0));
    q.push_back(mk(ZLO | PCE | MDRR | MDRE, 5'd0));
    q.push_back(mk(MDRO | IRE, 5'd0));
    case (op)
      MFHI: q.push_back(mk(GRA | RIN | HIO, 5'd0));
      MFLO: q.push_back(mk(GRA | RIN | LOO, 5'd0));
      ADD, SUB, AND_, OR_: begin
        q.push_back(mk(GRB | ROUT | YE, op));
        q.push_back(mk(GRC | ROUT | ZLI, op));
        q.push_back(mk(ZLO | GRA | RIN, op));
      end
      ADDI: begin
        q.push_back(mk(GRB | ROUT | YE, op));
        q.push_back(mk(COUT | ZLI, op));
        q.push_back(mk(ZLO | GRA | RIN, op));
      end
      MUL, DIV: begin
        q.push_back(mk(GRA | ROUT | YE, op));
        q.push_back(mk(GRB | ROUT | ZLI | ZHI, op));
        q.push_back(mk(ZLO | LOE, op));
        q.push_back(mk(ZHO | HIE, op));
      end
      LDI, LD, ST: begin
        q.push_back(mk(GRB | BAO | YE, 5'd0));
        q.push_back(mk(COUT | ZLI, ADD_OP));
        if (op == LDI) q.push_back(mk(ZLO | GRA | RIN, ADD_OP));
        else           q.push_back(mk(ZLO | MARE, ADD_OP));
        if (op == LD) begin
          q.push_back(mk(MDRR | MDRE, 5'd0));
          q.push_back(mk(MDRO | GRA | RIN, 5'd0));
        end else if (op == ST) begin
          q.push_back(mk(GRA | ROUT | MDRE, 5'd0));
          q.push_back(mk(RAMW, 5'd0));
        end
      end
      BR: begin
        q.push_back(mk(GRA | ROUT | CONE, 5'd0));
        q.push_back(mk(PCO | YE, ADD_OP));
        q.push_back(mk(COUT | ZLI, ADD_OP));
        q.push_back(mk(ZLO | (con ? PCE : 28'd0), 5'd0));
      end
      JR:  q.push_back(mk(GRA | ROUT | PCE, 5'd0));
      IN_: q.push_back(mk(INO | GRA | RIN, 5'd0));
      OUT: q.push_back(mk(GRA | ROUT | OUTE, 5'd0));
      default: q.push_back(mk(28'd0, 5'd0));
    endcase
  endtask

  task automatic test_reset();
    Clear = 1'b0;
    ifc.IR = 32'h0;
    ifc.CON_FF = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (got !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", got);
    end
    @(negedge Clock) Clear = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (got !== {PCO | MARE | INCPC | ZLI, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL first_t0 got %h expected %h", got, {PCO | MARE | INCPC | ZLI, 5'd0, 1'b1});
    end
  endtask

  task automatic test_fetch_exec();
    logic [4:0] ops [6] = '{MFHI, ADD, ST, LD, MUL, JR};
    exp_t e;
    int step;
    foreach (ops[i]) begin
      push_instr(ops[i], 1'b0);
      step = 0;
      while (q.size() > 0) begin
        e = q.pop_front();
        ifc.IR = {ops[i], 27'($urandom)};
        #1;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL exec op %b step %0d got %h expected %h", ops[i], step, got, e);
        end
        checks++;
        if ($countones(obs & BUS_MASK) > 1) begin
          errors++;
          $display("FAIL bus_exclusive op %b step %0d drivers %h expected at most one", ops[i], step, obs & BUS_MASK);
        end
        step++;
        @(posedge Clock);
        #1;
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    int step;
    for (int c = 0; c < 2; c++) begin
      push_instr(BR, c[0]);
      step = 0;
      while (q.size() > 0) begin
        e = q.pop_front();
        ifc.IR = {BR, 27'($urandom)};
        ifc.CON_FF = c[0];
        #1;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL br con %0d step %0d got %h expected %h", c, step, got, e);
        end
        checks++;
        if ($countones(obs & BUS_MASK) > 1) begin
          errors++;
          $display("FAIL bus_exclusive br step %0d drivers %h expected at most one", step, obs & BUS_MASK);
        end
        step++;
        @(posedge Clock);
        #1;
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [4:0] op;
    logic con;
    int step;
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == HALT) op = NOP;
      con = 1'($urandom);
      push_instr(op, con);
      step = 0;
      while (q.size() > 0) begin
        e = q.pop_front();
        ifc.IR = {op, 27'($urandom)};
        ifc.CON_FF = con;
        #1;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL random op %b con %b step %0d got %h expected %h", op, con, step, got, e);
        end
        checks++;
        if ($countones(obs & BUS_MASK) > 1) begin
          errors++;
          $display("FAIL bus_exclusive op %b step %0d drivers %h expected at most one", op, step, obs & BUS_MASK);
        end
        step++;
        @(posedge Clock);
        #1;
      end
    end
  endtask

  task automatic test_clear_mid();
    ifc.IR = {LD, 27'h123};
    repeat (5) @(posedge Clock);
    #1;
    checks++;
    if (got !== {ZLO | MARE, ADD_OP, 1'b1}) begin
      errors++;
      $display("FAIL ld_t5 got %h expected %h", got, {ZLO | MARE, ADD_OP, 1'b1});
    end
    #2 Clear = 1'b0;
    #1;
    checks++;
    if (got !== 34'd0) begin
      errors++;
      $display("FAIL async_clear got %h expected 0", got);
    end
    @(negedge Clock) Clear = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (got !== {PCO | MARE | INCPC | ZLI, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL t0_after_clear got %h expected %h", got, {PCO | MARE | INCPC | ZLI, 5'd0, 1'b1});
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int step = 0;
    push_instr(HALT, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      ifc.IR = 32'hD0000000;
      #1;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL halt_instr step %0d got %h expected %h", step, got, e);
      end
      step++;
      @(posedge Clock);
      #1;
    end
    for (int k = 0; k < 10; k++) begin
      ifc.IR = {5'($urandom), 27'($urandom)};
      ifc.CON_FF = 1'($urandom);
      #1;
      checks++;
      if (got !== 34'd0) begin
        errors++;
        $display("FAIL halted cycle %0d got %h expected 0", k, got);
      end
      @(posedge Clock);
      #1;
    end
    Clear = 1'b0;
    @(negedge Clock) Clear = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (got !== {PCO | MARE | INCPC | ZLI, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL halt_exit got %h expected %h", got, {PCO | MARE | INCPC | ZLI, 5'd0, 1'b1});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch_exec();
    test_branch();
    test_random();
    test_clear_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that generates every datapath control strobe from the latched instruction. It is the producer of the signals the datapath consumes.
- Owns the fetch/decode/execute state sequencing, one control step per clock.
- Sits beside `datapath`. It reads back the IR word and the CON flip-flop, and drives all register, bus, memory and I/O enables.

Parameters:
- OPW, 5, opcode field width; the opcode is IR[31:27].
- ADD_OP, 5'b00011, ALU operation forced during address and branch-target computation.

Ports:
- Clock  in  1  system clock; all state changes occur on the rising edge.
- Clear  in  1  reset, asynchronous, active-low.
- IR  in  32  instruction register contents.
- CON_FF  in  1  branch-condition flip-flop output.
- Run  out  1  high while executing; low in Reset_state and Halt.
- ALU_op  out  5  ALU operation select.
- Register and bus controls, out, 1 bit each: PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Gra, Grb, Grc, R_in, R_out.
- Load controls, out, 1 bit each: PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable, LO_enable, CON_enable, OutPort_enable, RAM_write.

Behaviour:
- States: Reset_state, T0..T7, Halt. Encoding is free.
- Outputs are a combinational decode of present state and IR[31:27]. Every output not listed for a step is 0.
- Clear=0 asynchronously forces Reset_state, even mid-instruction. In Reset_state all outputs are 0, ALU_op=0 and Run=0.
- The first rising edge with Clear=1 moves Reset_state to T0.

Fetch (all opcodes):
- T0: PCout, MAR_enable, IncPC, ZLowIn.
- T1: ZLowout, PC_enable, MDR_read, MDR_enable.
- T2: MDRout, IR_enable.
- T2 always advances to T3.

Execute steps (the last listed step returns to T0 at the next edge):
- mfhi 10111: T3 Gra, R_in, HIout.
- mflo 11000: T3 Gra, R_in, LOout.
- add 00011, sub 00100, and 01001, or 01010: T3 Grb, R_out, Y_enable; T4 Grc, R_out, ZLowIn; T5 ZLowout, Gra, R_in.
- addi 01011: T3 Grb, R_out, Y_enable; T4 Cout, ZLowIn; T5 ZLowout, Gra, R_in.
- mul 01110, div 01111: T3 Gra, R_out, Y_enable; T4 Grb, R_out, ZLowIn, ZHighIn; T5 ZLowout, LO_enable; T6 ZHighout, HI_enable.
- ldi 00001: T3 Grb, BAout, Y_enable; T4 Cout, ZLowIn; T5 ZLowout, Gra, R_in.
- ld 00000: T3-T4 as ldi; T5 ZLowout, MAR_enable; T6 MDR_read, MDR_enable; T7 MDRout, Gra, R_in.
- st 00010: T3-T5 as ld; T6 Gra, R_out, MDR_enable (MDR_read=0); T7 RAM_write.
- br 10010: T3 Gra, R_out, CON_enable; T4 PCout, Y_enable; T5 Cout, ZLowIn; T6 ZLowout, plus PC_enable only if CON_FF=1.
  - CON_FF is sampled during T6.
- jr 10011: T3 Gra, R_out, PC_enable.
- in 10101: T3 InPortout, Gra, R_in.
- out 10110: T3 Gra, R_out, OutPort_enable.
- nop 11001: T3 asserts nothing.
- halt 11010: T3 goes to Halt. In Halt all outputs are 0 and Run=0; the only exit is Clear.
- Any other opcode executes as nop: one empty T3, then T0.

ALU_op:
- Equals IR[31:27] in T3-T7 for add, sub, and, or, addi, mul, div.
- Equals ADD_OP in T4-T5 of ld, ldi, st, br.
- 0 otherwise.

Other rules:
- No simultaneous bus drivers. At most one of PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out is high in any state.
- IR changing outside T2 has no effect on the state path beyond T3's decode; the opcode is re-read combinationally each cycle.

Test Plan:
- Reset 0 for 2 cycles, then release → all outputs 0 during reset. First edge gives T0 with PCout=MAR_enable=IncPC=ZLowIn=1 and Run=1.
- IR=32'hB9000000 (mfhi) → T0,T1,T2 fetch strobes, then T3 Gra=R_in=HIout=1. The next cycle is T0 again (4-cycle instruction).
- IR=32'h18000000 (add) → T4 has Grc=R_out=ZLowIn=1 with ALU_op=5'b00011. T5 has Gra=R_in=ZLowout=1; back to T0 after 6 cycles.
- IR=32'h10000000 (st) → T5 MAR_enable=1 with ALU_op=ADD_OP, T6 MDR_enable=1 with MDR_read=0, T7 RAM_write=1 for exactly one cycle.
- br with CON_FF=0, then repeated with CON_FF=1 → PC_enable=0 in T6, then PC_enable=1 in T6. Bus-exclusivity assertion holds in every cycle.
- Clear pulsed low during T5 of ld → immediate Reset_state with all outputs 0. Separately, IR=32'hD0000000 (halt) → Halt, Run=0, outputs held at 0 for 10 cycles.
